// File: rtl/dnc_tc_ctrl_if.sv
// Bus bundle between the event-timer controller and its driver.
// The driver owns count_in/start/stop/target; the controller owns the
// status outputs plus a debug view of its FSM state.
interface dnc_tc_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) ();
  // Request protocol: start and stop are plain levels sampled on every
  // rising clock edge (no valid/ready pair). A request takes effect on the
  // edge where it is seen high; holding it high simply repeats it. stop has
  // priority over start, and start has priority over a terminal-count event.
  // target is only meaningful on an edge where start is accepted.
  logic [CNT_W-1:0] count_in;
  logic             start;
  logic             stop;
  logic [EVT_W-1:0] target;
  logic             tc_pulse;
  logic             busy;
  logic             done;
  logic [EVT_W-1:0] events;
  logic [1:0]       dbg_state;

  modport master (
    output count_in, start, stop, target,
    input  tc_pulse, busy, done, events, dbg_state
  );

  modport slave (
    input  count_in, start, stop, target,
    output tc_pulse, busy, done, events, dbg_state
  );
endinterface

// File: rtl/dnc_tc_ctrl.sv
// Terminal-count detector and start/stop event timer sitting behind a
// free-running down counter. Each fresh arrival of count_in at TC_VALUE
// produces a one-cycle tc_pulse; while armed, those arrivals are counted
// until the programmed target is reached, which turns the counter into a
// prescaler for longer timeouts.
module dnc_tc_ctrl #(
  parameter int             CNT_W    = 4,
  parameter int             EVT_W    = 8,
  parameter logic [CNT_W-1:0] TC_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst,
  dnc_tc_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_count_q;
  logic [EVT_W-1:0] target_q, target_d;
  logic [EVT_W-1:0] events_q, events_d;
  logic [EVT_W-1:0] events_inc;
  logic             tc_evt;
  logic             tc_pulse_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // A terminal count is only the first sample at TC_VALUE, so a held
  // value yields a single event. prev_count resets to all ones to match
  // the counter's own reset value.
  assign tc_evt     = (bus.count_in == TC_VALUE) && (prev_count_q != TC_VALUE);
  assign events_inc = events_q + 1'b1;

  // State register plus the datapath registers the FSM steers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_count_q <= '1;
      target_q     <= '0;
      events_q     <= '0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= bus.count_in;
      target_q     <= target_d;
      events_q     <= events_d;
    end
  end

  // Next-state and datapath update; priority is stop > start > tc_evt.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    events_d = events_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.stop) begin
          state_d  = IDLE;
          events_d = '0;
        end else if (bus.start) begin
          // A coincident terminal count is not counted: events restarts at 0.
          events_d = '0;
          if (bus.target != '0) begin
            target_d = bus.target;
            state_d  = RUN;
          end else begin
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          // Abort keeps the partial count visible until a later stop clears it.
          state_d = IDLE;
        end else if (tc_evt) begin
          events_d = events_inc;
          // events can never pass target_q, so it cannot wrap.
          if (events_inc == target_q) state_d = DONE;
        end
      end
      default: begin
        state_d  = IDLE;
        events_d = '0;
      end
    endcase
  end

  // Status decode from the state being entered, so the flags line up with it.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Registered status outputs and the terminal-count tick (active in all states).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_pulse_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tc_pulse_q <= tc_evt;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tc_pulse  = tc_pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.events    = events_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dnc_tc_ctrl.sv
// Directed bench for dnc_tc_ctrl: a behavioural down counter drives
// count_in, and each step checks hand-computed expected outputs.
module tb_dnc_tc_ctrl;

  localparam int CNT_W = 4;
  localparam int EVT_W = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic clk;
  logic rst;
  logic [CNT_W-1:0] cnt;
  logic hold;
  int n_checks;
  int n_errors;

  dnc_tc_ctrl_if #(.CNT_W(CNT_W), .EVT_W(EVT_W)) bus ();

  dnc_tc_ctrl #(.CNT_W(CNT_W), .EVT_W(EVT_W), .TC_VALUE(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Driver: advance n clocks; after each edge the counter steps down
  // (unless held) and the new value is driven away from the edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!hold) cnt = cnt - 1'b1;
      bus.count_in = cnt;
    end
  endtask

  task automatic chk_status(input string tag, input logic [1:0] st, input logic bsy,
                            input logic dn, input logic [7:0] ev);
    chk({tag, "_state"},  bus.dbg_state, st);
    chk({tag, "_busy"},   bus.busy,      bsy);
    chk({tag, "_done"},   bus.done,      dn);
    chk({tag, "_events"}, bus.events,    ev);
  endtask

  initial begin
    int pulses;
    int bad;
    int c;
    n_checks = 0;
    n_errors = 0;
    hold = 1'b0;
    cnt = 4'd15;
    rst = 1'b0;
    bus.count_in = cnt;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.target = '0;

    // Reset values while held in reset
    #5;
    chk_status("rst", S_IDLE, 1'b0, 1'b0, 8'd0);
    chk("rst_tc_pulse", bus.tc_pulse, 1'b0);
    #15;
    rst = 1'b1;

    // 1. Free run, no start: one tick per 16 cycles, controller idle
    pulses = 0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      if (bus.tc_pulse) pulses++;
      if (bus.busy || bus.done || bus.events != 0) bad++;
    end
    chk("free_pulses", pulses, 2);
    chk("free_idle_bad", bad, 0);

    // 2. Normal run, target=3, armed while count_in=12
    cyc(3);
    chk("pre_arm_count", bus.count_in, 12);
    bus.start = 1'b1;
    bus.target = 8'd3;
    cyc(1);
    bus.start = 1'b0;
    bus.target = 8'd9;
    chk_status("arm", S_RUN, 1'b1, 1'b0, 8'd0);
    cyc(11);
    chk_status("run_ev0", S_RUN, 1'b1, 1'b0, 8'd0);
    cyc(1);
    chk_status("run_ev1", S_RUN, 1'b1, 1'b0, 8'd1);
    chk("run_ev1_tick", bus.tc_pulse, 1'b1);
    cyc(16);
    chk_status("run_ev2", S_RUN, 1'b1, 1'b0, 8'd2);
    cyc(16);
    chk_status("run_ev3", S_DONE, 1'b0, 1'b1, 8'd3);
    cyc(1);
    chk("done_tick_low", bus.tc_pulse, 1'b0);
    chk_status("done_hold", S_DONE, 1'b0, 1'b1, 8'd3);

    // 3. Abort after two events, then a second stop clears events
    bus.start = 1'b1;
    bus.target = 8'd5;
    cyc(1);
    bus.start = 1'b0;
    chk_status("rearm", S_RUN, 1'b1, 1'b0, 8'd0);
    cyc(14);
    chk("abort_ev1", bus.events, 8'd1);
    cyc(16);
    chk("abort_ev2", bus.events, 8'd2);
    bus.stop = 1'b1;
    cyc(1);
    chk_status("abort", S_IDLE, 1'b0, 1'b0, 8'd2);
    cyc(1);
    bus.stop = 1'b0;
    chk_status("abort_clr", S_IDLE, 1'b0, 1'b0, 8'd0);

    // 4. count_in held at 0 for 6 samples during RUN: one event only
    bus.start = 1'b1;
    bus.target = 8'd4;
    cyc(1);
    bus.start = 1'b0;
    cyc(12);
    chk("hold_pre_count", bus.count_in, 0);
    hold = 1'b1;
    cyc(1);
    chk("hold_ev", bus.events, 8'd1);
    chk("hold_tick", bus.tc_pulse, 1'b1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (bus.tc_pulse) pulses++;
    end
    chk("hold_extra_ticks", pulses, 0);
    chk("hold_ev_after", bus.events, 8'd1);
    hold = 1'b0;
    cyc(1);
    chk_status("hold_exit", S_RUN, 1'b1, 1'b0, 8'd1);

    // 5c. stop coinciding with a terminal count in RUN
    cyc(15);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk_status("stop_tc", S_IDLE, 1'b0, 1'b0, 8'd1);
    chk("stop_tc_tick", bus.tc_pulse, 1'b1);

    // 5a. start and stop together in IDLE: stop wins
    bus.start = 1'b1;
    bus.stop = 1'b1;
    bus.target = 8'd7;
    cyc(1);
    bus.stop = 1'b0;
    bus.start = 1'b0;
    chk_status("start_stop", S_IDLE, 1'b0, 1'b0, 8'd0);

    // 5b. target=0 goes straight to DONE
    bus.start = 1'b1;
    bus.target = 8'd0;
    cyc(1);
    bus.start = 1'b0;
    chk_status("tgt0", S_DONE, 1'b0, 1'b1, 8'd0);

    // Largest target (255)
    c = int'(cnt);
    bus.start = 1'b1;
    bus.target = 8'd255;
    cyc(1);
    bus.start = 1'b0;
    cyc(c + 16 * 254 - 1);
    chk_status("max_254", S_RUN, 1'b1, 1'b0, 8'd254);
    cyc(1);
    chk_status("max_255", S_DONE, 1'b0, 1'b1, 8'd255);

    // start coinciding with a terminal count in DONE: event not counted
    cyc(15);
    bus.start = 1'b1;
    bus.target = 8'd3;
    cyc(1);
    bus.start = 1'b0;
    chk_status("start_tc", S_RUN, 1'b1, 1'b0, 8'd0);
    chk("start_tc_tick", bus.tc_pulse, 1'b1);
    cyc(16);
    chk("start_tc_ev1", bus.events, 8'd1);
    cyc(16);
    chk_status("pre_rst", S_RUN, 1'b1, 1'b0, 8'd2);
    chk("pre_rst_tick", bus.tc_pulse, 1'b1);

    // 6. Asynchronous reset between clock edges
    #4;
    rst = 1'b0;
    #1;
    chk_status("async_rst", S_IDLE, 1'b0, 1'b0, 8'd0);
    chk("async_rst_tick", bus.tc_pulse, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc(15);
    chk("post_rst_quiet", bus.tc_pulse, 1'b0);
    cyc(1);
    chk("post_rst_tick", bus.tc_pulse, 1'b1);
    chk_status("post_rst", S_IDLE, 1'b0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
